// File: rtl/conv_tap_multiplier_if.sv
// Handshake and product bus between the pixel/weight source and conv_tap_multiplier.
// The master modport is the operand source; the slave modport is the multiplier.
interface conv_tap_multiplier_if #(
  parameter int OP_W = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_pixel;
  logic [OP_W-1:0] in_weight;
  logic            tap_clr;
  logic            prod_valid;
  logic [OP_W-1:0] prod_out;
  logic [3:0]      tap_idx;
  logic            tap_last;
  logic            busy;

  modport master (
    output in_valid, in_pixel, in_weight, tap_clr,
    input  in_ready, prod_valid, prod_out, tap_idx, tap_last, busy
  );

  modport slave (
    input  in_valid, in_pixel, in_weight, tap_clr,
    output in_ready, prod_valid, prod_out, tap_idx, tap_last, busy
  );
endinterface

// File: rtl/conv_tap_multiplier.sv
// Sequential shift-add multiplier feeding the 3x3 convolution accumulator, with tap index tracking.
// Define MUL_SAT_EN to saturate products above 2^OP_W-1 instead of truncating them.
module conv_tap_multiplier #(
  parameter int TAPS = 9,
  parameter int OP_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_tap_multiplier_if.slave  bus
);

  localparam int PW    = 2 * OP_W;
  localparam int CNT_W = $clog2(OP_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [OP_W-1:0]  b_q, b_d;
  logic [PW-1:0]    partial_q, partial_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  prod_out_q, prod_out_d;
  logic             prod_valid_q, prod_valid_d;
  logic [3:0]       tap_idx_q, tap_idx_d;
  logic             tap_last_q, tap_last_d;
  logic             clr_pend_q, clr_pend_d;

  // One shifted partial product per multiplier bit; the counter picks this edge's term.
  logic [PW-1:0] pp [OP_W];
  generate
    for (genvar gi = 0; gi < OP_W; gi++) begin : g_pp
      assign pp[gi] = b_q[gi] ? (a_q << gi) : '0;
    end
  endgenerate

  logic [PW-1:0]   partial_sum;
  logic [OP_W-1:0] prod_sel;
  assign partial_sum = partial_q + pp[cnt_q];

`ifdef MUL_SAT_EN
  assign prod_sel = (|partial_sum[PW-1:OP_W]) ? '1 : partial_sum[OP_W-1:0];
`else
  assign prod_sel = partial_sum[OP_W-1:0];
`endif

  // A tap_clr arriving on the emission edge itself still makes this product tap 1.
  logic       tap_wrap;
  logic [3:0] tap_next;
  assign tap_wrap = (tap_idx_q == 4'(TAPS)) || (tap_idx_q == 4'd0) || clr_pend_q || bus.tap_clr;
  assign tap_next = tap_wrap ? 4'd1 : tap_idx_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    partial_d    = partial_q;
    cnt_d        = cnt_q;
    prod_out_d   = prod_out_q;
    prod_valid_d = 1'b0;
    tap_idx_d    = tap_idx_q;
    tap_last_d   = 1'b0;
    clr_pend_d   = clr_pend_q | bus.tap_clr;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d       = PW'(bus.in_pixel);
          b_d       = bus.in_weight;
          partial_d = '0;
          cnt_d     = '0;
          state_d   = MUL;
        end
      end
      MUL: begin
        partial_d = partial_sum;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d      = DONE;
          prod_out_d   = prod_sel;
          prod_valid_d = 1'b1;
          tap_idx_d    = tap_next;
          tap_last_d   = (tap_next == 4'(TAPS));
          clr_pend_d   = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      partial_q    <= '0;
      cnt_q        <= '0;
      prod_out_q   <= '0;
      prod_valid_q <= 1'b0;
      tap_idx_q    <= 4'd0;
      tap_last_q   <= 1'b0;
      clr_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      partial_q    <= partial_d;
      cnt_q        <= cnt_d;
      prod_out_q   <= prod_out_d;
      prod_valid_q <= prod_valid_d;
      tap_idx_q    <= tap_idx_d;
      tap_last_q   <= tap_last_d;
      clr_pend_q   <= clr_pend_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.prod_valid = prod_valid_q;
  assign bus.prod_out   = prod_out_q;
  assign bus.tap_idx    = tap_idx_q;
  assign bus.tap_last   = tap_last_q;

endmodule

// File: doc/conv_tap_multiplier.md
Name: conv_tap_multiplier

Overview:
Upstream stage of the 3x3 convolution accumulator. It accepts one unsigned 8-bit pixel/weight pair per handshake and multiplies them with a sequential shift-add unit. It emits one 8-bit product with a single-cycle valid pulse, which drives the accumulator's valid and data inputs directly. It also tracks the tap index 1..9 so that downstream logic and the testbench can see window boundaries.

Parameters:
TAPS, 9, products per convolution window; tap index wraps from TAPS back to 1
OP_W, 8, operand and product output width; product register is 2*OP_W internally

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  pixel/weight pair present
in_ready  out  1  block can accept a pair this cycle
in_pixel  in  OP_W  unsigned pixel operand
in_weight  in  OP_W  unsigned weight operand
tap_clr  in  1  restart tap numbering at next emitted product
prod_valid  out  1  one-cycle pulse; connects to accumulator valid
prod_out  out  OP_W  product; connects to accumulator data input
tap_idx  out  4  tap number of the current/last emitted product, 1..TAPS; 0 after reset
tap_last  out  1  high with prod_valid when tap_idx == TAPS
busy  out  1  state != IDLE

Behaviour:
- Reset: synchronous, evaluated only at posedge clk with rst=1.
  - Outputs after reset: state IDLE, prod_valid=0, prod_out=0, tap_idx=0, tap_last=0, busy=0, in_ready=1.
  - Internal registers: partial=0, bit counter=0.
  - rst takes priority over every other input.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture in_pixel into A (zero-extended to 2*OP_W) and in_weight into B, clear partial and bit counter, then go to MUL.
- MUL:
  - in_ready=0. One bit per edge: if B[cnt] is set, partial += A<<cnt (mod 2^(2*OP_W)); then cnt++.
  - After the edge that processes cnt=OP_W-1 (8 MUL edges), go to DONE.
  - At that same edge, register prod_out = partial_final[OP_W-1:0] and set prod_valid=1.
- DONE:
  - prod_valid=1 for exactly this one cycle; in_ready=0. Next edge returns to IDLE and clears prod_valid.
  - prod_out holds its value until the next product.
- Latency: acceptance edge E0; prod_valid high between edges E8 and E9; in_ready high again after E9.
- Throughput: one product per 10 cycles when in_valid is held high.
- Tap index update, at the edge that sets prod_valid:
  - tap_idx becomes 1 if tap_idx == TAPS, tap_idx == 0, or tap_clr is pending; otherwise tap_idx+1.
  - tap_last is registered alongside, =1 iff the new tap_idx == TAPS; it clears with prod_valid.
- tap_clr:
  - Sampled on any edge; sets a sticky pending flag.
  - The flag is consumed by the next product emission.
  - If tap_clr and the emission edge coincide, that product is tap 1.
  - tap_clr never aborts a multiplication in progress.
- Arithmetic: unsigned only. The full 16-bit product is formed and the low 8 bits are emitted (truncation, modulo 256), matching the accumulator's 8-bit wrap.
- in_valid while not IDLE: ignored; the source must hold its data until in_ready=1.
- Reset mid-MUL or mid-DONE: the product is discarded, no prod_valid pulse occurs, and tap numbering restarts at 0.

Optional Feature:
MUL_SAT_EN
- Defined: if partial_final > 2^OP_W-1, prod_out = 2^OP_W-1 (255); otherwise the low bits. Latency is unchanged.
- Undefined: plain truncation to the low OP_W bits.

Test Plan:
- Reset, then idle 5 cycles -> prod_valid=0, prod_out=0, tap_idx=0, in_ready=1, busy=0.
- Pair (pixel=12, weight=10) accepted at E0 -> prod_valid pulses only between E8 and E9; prod_out=120, tap_idx=1, tap_last=0.
- Nine back-to-back pairs (3,3) with in_valid held high -> nine pulses spaced 10 cycles apart, each prod_out=9.
  - tap_idx runs 1..9 with tap_last only on the 9th.
  - A tenth pair gives tap_idx=1.
- Pair (200,3):
  - Without macro -> prod_out=600 mod 256=88.
  - With MUL_SAT_EN -> prod_out=255.
  - Pair (255,255) -> 1 without the macro, 255 with it.
- tap_clr pulsed during the MUL of the 4th tap -> that product reports tap_idx=1; the following product reports tap_idx=2.
- rst asserted at the 4th MUL cycle of pair (5,5) -> no prod_valid pulse.
  - After reset, pair (2,7) yields prod_out=14 with tap_idx=1.
  - in_valid during MUL is ignored (operands not recaptured).
